insert_fifo: RTL
================

// Module: insert_fifo
// PURPOSE
//  Transmit-side counterpart of the 128-bit FIFO extractor: accepts one 128-bit
//  block (AES ciphertext) and serializes it MSB-byte-first into an 8-bit
//  output data FIFO, one push per accepted byte. Sits between the AES core
//  output and the USB TX data FIFO. Honors FIFO back-pressure.
// PARAMETERS
//  BLOCK_W  128  width of parallel input block, bits
//  BYTE_W   8    width of FIFO write port, bits; NUM_BYTES = BLOCK_W/BYTE_W (16)
// PORTS
//  clk        in   1        system clock, all logic on rising edge
//  rst        in   1        asynchronous, active-high reset
//  load       in   1        block-valid strobe; sampled only in IDLE
//  block_in   in   BLOCK_W  block to send; captured on the accepted load edge
//  fifo_full  in   1        downstream FIFO full; no push while high
//  push       out  1        FIFO write enable, one byte per high cycle
//  wdata      out  BYTE_W   byte presented with push
//  busy       out  1        high from the cycle after load is accepted until return to IDLE
//  done       out  1        one-cycle pulse after the last byte is pushed
// BEHAVIOUR
//  Reset: state=IDLE, shift reg=0, byte count=0; push=0, wdata=0, busy=0, done=0.
//  States: IDLE -> SEND -> DONE -> IDLE.
//   IDLE: busy=0. On edge with load=1: shift reg <= block_in, count <= 0, -> SEND.
//   SEND: busy=1. push = !fifo_full (combinational from state + fifo_full);
//         wdata = shift reg [BLOCK_W-1 -: BYTE_W] at all times in SEND.
//         On edge with push=1: shift reg <<= BYTE_W (zero fill), count++.
//         If count==NUM_BYTES-1 and push=1 -> DONE. fifo_full=1: hold everything.
//   DONE: busy=1, done=1, push=0 for exactly one cycle -> IDLE.
//  Byte order: first pushed byte = block_in[127:120], last = block_in[7:0].
//  Latency (no back-pressure): load at edge 0; pushes in cycles 1..16; done in
//   cycle 17; next load accepted at edge 18. Each full cycle adds one cycle.
//  load while busy (SEND/DONE): ignored; block_in not re-sampled; no error flag.
//  Outside SEND: push=0, wdata=0.
//  fifo_full toggling every cycle: exactly 16 pushes total, no byte lost/duplicated.
//  Reset mid-block: immediate return to IDLE, partial block dropped, no done.
//  Count is $clog2(NUM_BYTES) bits; never wraps (exit at NUM_BYTES-1).
// STRUCTURE
//  Shared package aes_fifo_pkg: BLOCK_W/BYTE_W defaults, NUM_BYTES, state enum
//   typedef (IDLE, SEND, DONE) shared with the extractor side.
//  Single module: one always_ff (state, shift reg, count), one always_comb
//   (next state, push, wdata, done, busy) with full defaults; no sub-module.
// TESTING
//  1 Reset assert: all outputs 0; release, no load -> stays IDLE, push never high.
//  2 load, block_in=0x00112233_44556677_8899AABB_CCDDEEFF, full=0 -> wdata 00,11,..,FF
//    on 16 consecutive push cycles, done in cycle 17, busy 1 for cycles 1..17.
//  3 Same block, fifo_full high for cycles 3..7 -> push low cycles 3..7, byte 0x22
//    pushed in cycle 8, total 16 pushes in order, done in cycle 22.
//  4 Second load (block 0xFF..FF) asserted at cycle 5 of first block -> ignored;
//    only first block's 16 bytes pushed, one done pulse.
//  5 rst asserted after 6th push -> outputs 0 next cycle-independent (async),
//    no done; new load of 0xA5..A5 -> 16 pushes of 0xA5.
//  6 Back-to-back: load held high continuously -> blocks accepted at edges 0, 18,
//    36; no gap/overlap in byte stream beyond the DONE/IDLE cycles.

Source files
------------

// File: rtl/aes_fifo_pkg.sv
// Definitions shared by the AES block/byte FIFO adapters (extractor and inserter):
// default widths and the three-state sequencing enum.
package aes_fifo_pkg;

   localparam int DEF_BLOCK_W = 128;
   localparam int DEF_BYTE_W  = 8;
   localparam int NUM_BYTES   = DEF_BLOCK_W / DEF_BYTE_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/insert_fifo.sv
// Serializes one BLOCK_W-bit block MSB-byte-first into a byte-wide FIFO,
// stalling on fifo_full and pulsing done for one cycle after the last byte.
module insert_fifo
   import aes_fifo_pkg::*;
#(
   parameter int BLOCK_W = DEF_BLOCK_W,
   parameter int BYTE_W  = DEF_BYTE_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [BLOCK_W-1:0] block_in,
   input  logic               fifo_full,
   output logic               push,
   output logic [BYTE_W-1:0]  wdata,
   output logic               busy,
   output logic               done
);

   localparam int N_BYTES = BLOCK_W / BYTE_W;
   localparam int CNT_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_BYTES - 1);

   state_e             state_q, state_d;
   logic [BLOCK_W-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      push    = 1'b0;
      wdata   = '0;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (load) begin
               shreg_d = block_in;
               cnt_d   = '0;
               state_d = SEND;
            end
         end
         SEND: begin
            busy  = 1'b1;
            push  = !fifo_full;
            wdata = shreg_q[BLOCK_W-1 -: BYTE_W];
            if (!fifo_full) begin
               shreg_d = shreg_q << BYTE_W;
               // Counter stops at the last index instead of wrapping.
               if (cnt_q == LAST_CNT) state_d = DONE;
               else                   cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
